// File: rtl/seq_pair_feeder.sv
// Pair-issuing reduction controller for pipelined_adder: buffers operands and
// recirculated partial sums, emits one sum per SEQ_LEN operands. Optional
// cycle statistics port enabled by defining SEQ_PAIR_FEEDER_STATS_EN.
module seq_pair_feeder #(
  parameter int INP_DW     = 8,
  parameter int NUM_REG    = 4,
  parameter int SEQ_LEN    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INP_DW-1:0] in_data,
  output logic              in_ready,
  output logic [INP_DW-1:0] add_inp1,
  output logic [INP_DW-1:0] add_inp2,
  input  logic [INP_DW-1:0] add_outp,
  output logic              out_valid,
  output logic [INP_DW-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
`ifdef SEQ_PAIR_FEEDER_STATS_EN
  ,
  output logic [15:0]       seq_cycles
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(SEQ_LEN + 1);
  localparam int IW = $clog2(NUM_REG + 1);

  typedef enum logic {ACCUM, OUT} state_t;

  state_t            state;
  logic [INP_DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [NUM_REG:1]  vld;
  logic [SW-1:0]     in_cnt;
  logic [SW-1:0]     add_cnt;
  logic [IW-1:0]     inflight;
  logic              accept;
  logic              issue;
  logic              res_push;
  logic              out_pop;
  logic              done_next;
  logic [INP_DW-1:0] head;
  logic [INP_DW-1:0] head2;
  int                fifo_nxt;
  int                inflight_nxt;
  int                in_nxt;
  int                add_nxt;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
    return PW'(s);
  endfunction

  always_comb begin
    inflight  = IW'($countones(vld));
    head      = mem[rd_ptr];
    head2     = mem[ptr_add(rd_ptr, 1)];
    res_push  = vld[NUM_REG];
    in_ready  = (state == ACCUM) && (int'(in_cnt) < SEQ_LEN) &&
                (int'(fifo_cnt) + int'(inflight) + 1 <= FIFO_DEPTH);
    accept    = in_valid && in_ready;
    issue     = (state == ACCUM) && (fifo_cnt >= CW'(2));
    out_pop   = (state == OUT) && out_ready;
    add_inp1  = issue ? head  : '0;
    add_inp2  = issue ? head2 : '0;
    out_valid = (state == OUT);
    out_data  = (state == OUT) ? head : '0;
    busy      = ((state == ACCUM) && (in_cnt != '0)) || (state == OUT);

    fifo_nxt     = int'(fifo_cnt) + int'(res_push) + int'(accept)
                 - (issue ? 2 : 0) - (out_pop ? 1 : 0);
    inflight_nxt = int'(inflight) + int'(issue) - int'(res_push);
    in_nxt       = int'(in_cnt) + int'(accept);
    add_nxt      = int'(add_cnt) + int'(issue);
    // Look at next-cycle counts so out_valid rises right after the last push.
    done_next    = (state == ACCUM) && (in_nxt == SEQ_LEN) &&
                   (add_nxt == SEQ_LEN - 1) && (inflight_nxt == 0) && (fifo_nxt == 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      vld      <= '0;
      in_cnt   <= '0;
      add_cnt  <= '0;
    end else begin
      vld[1] <= issue;
      for (int k = 2; k <= NUM_REG; k++) vld[k] <= vld[k-1];
      // Adder result takes the first free slot, the new operand the next.
      if (res_push) mem[wr_ptr] <= add_outp;
      if (accept) mem[res_push ? ptr_add(wr_ptr, 1) : wr_ptr] <= in_data;
      wr_ptr   <= ptr_add(wr_ptr, int'(res_push) + int'(accept));
      rd_ptr   <= ptr_add(rd_ptr, issue ? 2 : (out_pop ? 1 : 0));
      fifo_cnt <= CW'(fifo_nxt);
      if (out_pop) begin
        in_cnt  <= '0;
        add_cnt <= '0;
        state   <= ACCUM;
      end else begin
        in_cnt  <= SW'(in_nxt);
        add_cnt <= SW'(add_nxt);
        if (done_next) state <= OUT;
      end
    end
  end

`ifdef SEQ_PAIR_FEEDER_STATS_EN
  logic stats_run;

  // Span runs from the first accept through the first out_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cycles <= '0;
      stats_run  <= 1'b0;
    end else if (accept && (in_cnt == '0)) begin
      seq_cycles <= 16'd1;
      stats_run  <= 1'b1;
    end else if (stats_run) begin
      if (seq_cycles != 16'hFFFF) seq_cycles <= seq_cycles + 16'd1;
      if (state == OUT) stats_run <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_pair_feeder.sv
// Self-checking bench for seq_pair_feeder driving a behavioural pipelined adder;
// checks sums, issue counts, occupancy, latency, backpressure and reset.
module tb_seq_pair_feeder;

  localparam int INP_DW     = 8;
  localparam int NUM_REG    = 4;
  localparam int SEQ_LEN    = 8;
  localparam int FIFO_DEPTH = 6;
  localparam int LAT_BOUND  = SEQ_LEN + $clog2(SEQ_LEN) * (NUM_REG + 1) + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [INP_DW-1:0] in_data;
  logic              in_ready;
  logic [INP_DW-1:0] add_inp1;
  logic [INP_DW-1:0] add_inp2;
  logic [INP_DW-1:0] add_outp;
  logic              out_valid;
  logic [INP_DW-1:0] out_data;
  logic              out_ready;
  logic              busy;
`ifdef SEQ_PAIR_FEEDER_STATS_EN
  logic [15:0]       seq_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [INP_DW-1:0] pipe [NUM_REG];
  logic [INP_DW-1:0] ops  [SEQ_LEN];

  seq_pair_feeder #(
    .INP_DW(INP_DW), .NUM_REG(NUM_REG), .SEQ_LEN(SEQ_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_inp1(add_inp1), .add_inp2(add_inp2), .add_outp(add_outp),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
`ifdef SEQ_PAIR_FEEDER_STATS_EN
    , .seq_cycles(seq_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural adder: NUM_REG register stages, never reset, so stale sums survive rst.
  always @(posedge clk) begin
    pipe[0] <= add_inp1 + add_inp2;
    for (int k = 1; k < NUM_REG; k++) pipe[k] <= pipe[k-1];
  end
  assign add_outp = pipe[NUM_REG-1];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Feeds ops[] as one sequence; operands are nonzero and partial sums never
  // wrap to zero, so a nonzero adder input pair marks an issue cycle.
  task automatic applyStimulus(input string tag, input bit gaps, input int stall);
    int idx = 0, issues = 0, cyc = 0, first_acc = -1, ov_cyc = -1;
    int stall_left = stall, max_occ = 0;
    bit done = 1'b0;
    logic [INP_DW-1:0] held = '0, exp_sum = '0;
    for (int i = 0; i < SEQ_LEN; i++) exp_sum = exp_sum + ops[i];
    out_ready = (stall == 0);
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (idx - issues > max_occ) max_occ = idx - issues;
      if (out_valid) begin
        if (ov_cyc < 0) begin
          ov_cyc = cyc;
          held   = out_data;
          checkOutput({tag, "_sum"}, out_data, exp_sum);
          checkOutput({tag, "_busy"}, busy, 1);
        end else begin
          checkOutput({tag, "_hold_data"}, out_data, held);
          checkOutput({tag, "_hold_noready"}, in_ready, 0);
          checkOutput({tag, "_hold_noissue"}, {add_inp1, add_inp2}, 0);
        end
        if (stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else begin
          out_ready = 1'b1;
          done      = 1'b1;
        end
      end else if (add_inp1 != 0 || add_inp2 != 0) begin
        issues++;
      end
      in_valid = (idx < SEQ_LEN) && (!gaps || ($urandom_range(0, 1) == 1));
      in_data  = in_valid ? ops[idx] : '0;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput({tag, "_completed"}, done, 1);
    checkOutput({tag, "_issues"}, issues, SEQ_LEN - 1);
    checkOutput($sformatf("%s_occupancy_max_%0d", tag, max_occ), max_occ <= FIFO_DEPTH, 1);
    if (!gaps)
      checkOutput($sformatf("%s_latency_%0d", tag, ov_cyc - first_acc),
                  (ov_cyc - first_acc) <= LAT_BOUND, 1);
    @(negedge clk);
    checkOutput({tag, "_ov_single"}, out_valid, 0);
    checkOutput({tag, "_ready_back"}, in_ready, 1);
    checkOutput({tag, "_idle"}, busy, 0);
`ifdef SEQ_PAIR_FEEDER_STATS_EN
    checkOutput({tag, "_seq_cycles"}, seq_cycles, ov_cyc - first_acc + 1);
`endif
    out_ready = 1'b0;
  endtask

  // Directed scenario list, executed in order.
  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_add_inp1", add_inp1, 0);
    checkOutput("rst_add_inp2", add_inp2, 0);
    checkOutput("rst_busy", busy, 0);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'(i + 1);
    applyStimulus("normal", 1'b0, 0);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = 8'hFF;
    applyStimulus("wrap", 1'b0, 0);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'($urandom_range(1, 15));
    applyStimulus("backpressure", 1'b0, 5);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'(2 * i + 3);
    applyStimulus("gaps_odd", 1'b1, 0);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'($urandom_range(1, 15));
    applyStimulus("gaps_rand", 1'b1, 2);

    acc = 0;
    for (int c = 0; c < 40 && acc < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd50;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midseq_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midseq_rst_ready", in_ready, 1);
    checkOutput("midseq_rst_idle", busy, 0);
    for (int i = 0; i < SEQ_LEN; i++) ops[i] = 8'd2;
    applyStimulus("after_rst", 1'b0, 0);

    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'($urandom_range(1, 15));
    applyStimulus("b2b_first", 1'b0, 0);
    for (int i = 0; i < SEQ_LEN; i++) ops[i] = INP_DW'($urandom_range(1, 15));
    applyStimulus("b2b_second", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pair_feeder.md
# seq_pair_feeder

- Upstream controller for `pipelined_adder`.
- Accepts a stream of `SEQ_LEN` operands and reduces them to one sum by repeatedly issuing operand pairs into the adder.
- Recirculates partial sums from the adder output back into its own operand buffer.
- Presents the final sum on a valid/ready output, then starts the next sequence.

## Interface
- `INP_DW`, 8, operand/sum width; must equal the adder's `INP_DW`.
- `NUM_REG`, 4, adder pipeline depth; must equal the adder's `NUM_REG`.
- `SEQ_LEN`, 8, operands per sequence; must be ≥2.
- `FIFO_DEPTH`, 8, operand buffer entries; must be ≥`NUM_REG`+2.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand offered.
- `in_data` in `INP_DW`: operand value.
- `in_ready` out 1: operand accepted when `in_valid`&&`in_ready`.
- `add_inp1` out `INP_DW`: to adder `inp1`.
- `add_inp2` out `INP_DW`: to adder `inp2`.
- `add_outp` in `INP_DW`: from adder `outp`.
- `out_valid` out 1: final sum available.
- `out_data` out `INP_DW`: final sum.
- `out_ready` in 1: consumer takes sum.
- `busy` out 1: sequence in progress (state ACCUM with `in_cnt`>0, or OUT).

## Operation
- Operand buffer:
  - FIFO of `FIFO_DEPTH` entries.
  - Up to 2 pushes per cycle, in order: adder result first, then accepted input.
  - Up to 2 pops per cycle.
- In-flight tracking:
  - `vld[1..NUM_REG]` shift register.
  - `vld[1]` <= issue; `vld[k]` <= `vld[k-1]`.
  - `vld[NUM_REG]`=1 means `add_outp` is a valid partial sum and is pushed that cycle.
  - `inflight` = popcount of `vld`.
- Counters:
  - `in_cnt` counts operands accepted, 0..`SEQ_LEN`.
  - `add_cnt` counts pairs issued, 0..`SEQ_LEN`-1.
- States: ACCUM, OUT.
- ACCUM behaviour:
  - `in_ready` = (`in_cnt`<`SEQ_LEN`) && (`fifo_cnt`+`inflight`+1 ≤ `FIFO_DEPTH`). Registered counts only; same-cycle pops are not credited.
  - Issue when `fifo_cnt`≥2 (registered):
    - pop head → `add_inp1`, head+1 → `add_inp2`;
    - `add_cnt`++.
  - When not issuing, `add_inp1`/`add_inp2` = 0.
  - ACCUM→OUT when `in_cnt`==`SEQ_LEN`, `add_cnt`==`SEQ_LEN`-1, `inflight`==0 and `fifo_cnt`==1.
- OUT behaviour:
  - `out_valid`=1; `out_data` = FIFO head, held stable.
  - `in_ready`=0; no issue.
  - On `out_ready`: pop, clear `in_cnt`/`add_cnt`, go to ACCUM.
- Arithmetic: sums wrap modulo 2^`INP_DW`, no saturation or carry-out.
- Issue order: order of addition is irrelevant; pair order is FIFO order.
- Reset:
  - state=ACCUM; FIFO empty; `vld`=0; counters=0.
  - `in_ready`=1 (the first cycle after reset).
  - `out_valid`=0, `out_data`=0, `add_inp1`=`add_inp2`=0, `busy`=0.
- Reset mid-sequence:
  - Discards all buffered and in-flight operands.
  - Adder outputs arriving after reset are ignored, because `vld` is cleared.

## Timing
- Issue in cycle t: `add_outp` is valid and pushed in cycle t+`NUM_REG`.
- Pushed data is poppable from cycle t+`NUM_REG`+1.
- `in_ready` is combinational from registered state, with no dependency on `in_valid`.
- `out_valid` rises the cycle after the final partial sum is pushed.
- With `SEQ_LEN`=8, `NUM_REG`=4 and continuous input, the tree has 3 levels.
- Total latency from first accept to `out_valid` ≤ `SEQ_LEN` + ⌈log2 `SEQ_LEN`⌉·(`NUM_REG`+1) + 2 cycles.
- Back-to-back sequences: `in_ready` rises the cycle after the `out_valid`&&`out_ready` handshake.

## Configuration
- `SEQ_PAIR_FEEDER_STATS_EN`
  - Defined:
    - Adds output `seq_cycles`, 16 bits, reset 0.
    - Counts cycles from first accept of a sequence up to and including the first `out_valid` cycle.
    - Saturates at 16'hFFFF.
    - Holds the value until the next sequence's first accept.
  - Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Normal sum:
  - Stimulus: `in_data` 1..8 on consecutive cycles, `out_ready`=1.
  - Expect: exactly 7 issues; `out_valid` for one cycle with `out_data`=36; within the latency bound.
- Wrap-around:
  - Stimulus: eight operands of 8'hFF.
  - Expect: `out_data`=8'hF8.
- Output backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after `out_valid` rises.
  - Expect: `out_data` stable, `in_ready`=0, no issues; then handshake, and `in_ready`=1 the next cycle.
- Input gaps and FIFO full:
  - Stimulus: `FIFO_DEPTH`=6, `NUM_REG`=4, `in_valid` toggling randomly.
  - Expect: `fifo_cnt`+`inflight` never exceeds 6; sum correct (e.g. 3,5,7,9,11,13,15,17 → 80).
- Reset mid-sequence:
  - Stimulus: `rst` pulsed 2 cycles after 5 operands accepted, with pairs in flight; then operands 2×8 applied.
  - Expect: `out_data`=16 (stale adder results ignored).
- Back-to-back and stats:
  - Stimulus: two consecutive sequences.
  - Expect: both sums correct.
  - With `SEQ_PAIR_FEEDER_STATS_EN`: `seq_cycles` equals the measured first-accept-to-`out_valid` span.
